// File: rtl/usbf_dma_arb.sv
// Round-robin arbiter sharing the function-core DMA channel among endpoints.
// One grant at a time: START pulse, WAIT for done or timeout, one GAP cycle.
module usbf_dma_arb #(
    parameter int NUM_EP  = 16,
    parameter int EP_W    = 4,
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_EP-1:0] ep_dma_req,
    input  logic [NUM_EP-1:0] ep_en,
    output logic [NUM_EP-1:0] ep_dma_ack,
    output logic              dma_start,
    output logic [EP_W-1:0]   dma_ep,
    output logic              dma_busy,
    input  logic              dma_done,
    output logic              tmo_err,
    output logic [15:0]       xfer_cnt
);

    localparam int EXT_W = 2 ** EP_W;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

    state_t            r_state;
    logic [EP_W-1:0]   r_rr_ptr;
    logic [EP_W-1:0]   r_ep;
    logic [TMO_W-1:0]  r_tmo;
    logic [NUM_EP-1:0] r_ack;
    logic              r_start;
    logic              r_busy;
    logic              r_tmo_err;
    logic [15:0]       r_cnt;

    logic [EXT_W-1:0]  w_elig;
    logic              w_hit;
    logic [EP_W-1:0]   w_sel;
    logic [EP_W-1:0]   w_next_rr;
    logic              w_tmo_hit;

    // Zero-extended to the full index space so an EP_W-bit index never runs off the end.
    assign w_elig    = EXT_W'(ep_dma_req & ep_en);
    assign w_next_rr = (32'(r_ep) == 32'(NUM_EP - 1)) ? '0 : r_ep + EP_W'(1);
    assign w_tmo_hit = (r_tmo == TMO_W'(TMO_CYC - 1));

    always_comb begin
        int unsigned     sum;
        logic [EP_W-1:0] idx;
        w_hit = 1'b0;
        w_sel = '0;
        sum   = 0;
        idx   = '0;
        for (int unsigned i = 0; i < 32'(NUM_EP); i++) begin
            sum = 32'(r_rr_ptr) + i;
            if (sum >= 32'(NUM_EP)) sum = sum - 32'(NUM_EP);
            idx = EP_W'(sum);
            if (!w_hit && w_elig[idx]) begin
                w_hit = 1'b1;
                w_sel = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_ep      <= '0;
            r_tmo     <= '0;
            r_ack     <= '0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_tmo_err <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_ack     <= '0;
            r_start   <= 1'b0;
            r_tmo_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_ep    <= w_sel;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_tmo   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (dma_done) begin
                        r_ack    <= NUM_EP'(1) << r_ep;
                        r_cnt    <= r_cnt + 16'd1;
                        r_rr_ptr <= w_next_rr;
                        r_state  <= S_GAP;
                    end else if (w_tmo_hit) begin
                        r_tmo_err <= 1'b1;
                        r_rr_ptr  <= w_next_rr;
                        r_state   <= S_GAP;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_GAP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ep_dma_ack = r_ack;
    assign dma_start  = r_start;
    assign dma_ep     = r_ep;
    assign dma_busy   = r_busy;
    assign tmo_err    = r_tmo_err;
    assign xfer_cnt   = r_cnt;

endmodule

// File: tb/tb_usbf_dma_arb.sv
// Bench for usbf_dma_arb: vector table, directed corner sequences, and a
// randomized run checked against a transaction-level reference model.
module tb_usbf_dma_arb;

    localparam int N   = 16;
    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;
    logic [15:0] en  = '0;
    logic        done = 1'b0;
    logic [15:0] ep_dma_ack;
    logic        dma_start;
    logic [3:0]  dma_ep;
    logic        dma_busy;
    logic        tmo_err;
    logic [15:0] xfer_cnt;

    int checks   = 0;
    int failures = 0;

    usbf_dma_arb #(.NUM_EP(N), .EP_W(4), .TMO_W(8), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .ep_dma_req(req), .ep_en(en),
        .ep_dma_ack(ep_dma_ack), .dma_start(dma_start), .dma_ep(dma_ep),
        .dma_busy(dma_busy), .dma_done(done), .tmo_err(tmo_err), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 free, 1 start, 2 waiting, 3 gap; grant picks the
    // eligible endpoint at the smallest rotational distance from the pointer.
    int          m_phase, m_rr, m_waits;
    logic [3:0]  m_ep;
    logic [15:0] m_ack, m_cnt;
    logic        m_start, m_busy, m_tmo;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_rr = 0; m_waits = 0; m_ep = '0; m_ack = '0;
            m_cnt = '0; m_start = 1'b0; m_busy = 1'b0; m_tmo = 1'b0;
        end else begin
            m_ack = '0; m_start = 1'b0; m_tmo = 1'b0;
            case (m_phase)
                0: begin
                    int best, bestd, d;
                    best = -1; bestd = N;
                    for (int i = 0; i < N; i++) begin
                        if (((req & en) >> i) & 16'h1) begin
                            d = (i - m_rr + N) % N;
                            if (d < bestd) begin bestd = d; best = i; end
                        end
                    end
                    if (best >= 0) begin
                        m_ep = 4'(best); m_phase = 1; m_start = 1'b1; m_busy = 1'b1;
                    end
                end
                1: begin m_phase = 2; m_waits = 0; end
                2: begin
                    m_waits++;
                    if (done) begin
                        m_ack = 16'h1 << m_ep; m_cnt = m_cnt + 16'd1;
                        m_rr = (int'(m_ep) + 1) % N; m_phase = 3;
                    end else if (m_waits == TMO) begin
                        m_tmo = 1'b1; m_rr = (int'(m_ep) + 1) % N; m_phase = 3;
                    end
                end
                default: begin m_phase = 0; m_busy = 1'b0; end
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (dma_start) begin ok = 1'b1; break; end
            step();
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL wait_start: no dma_start within %0d cycles", bound);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; en = '0; done = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    function automatic logic [63:0] outs();
        return 64'({ep_dma_ack, dma_start, dma_ep, dma_busy, tmo_err, xfer_cnt});
    endfunction

    typedef struct {
        logic [15:0] req, en;
        logic        done;
        logic        start, busy;
        logic [3:0]  ep;
        logic [15:0] ack, cnt;
    } vec_t;

    vec_t tbl[20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n, acks, busy_cyc;
        bit tseen;
        logic [3:0] rr_exp[6];

        tbl[0]  = '{16'h0008, 16'hFFFF, 1'b0, 1'b1, 1'b1, 4'd3, 16'h0000, 16'd0};
        tbl[1]  = '{16'h0008, 16'hFFFF, 1'b1, 1'b0, 1'b1, 4'd3, 16'h0000, 16'd0};
        tbl[2]  = '{16'h0008, 16'hFFFF, 1'b0, 1'b0, 1'b1, 4'd3, 16'h0000, 16'd0};
        tbl[3]  = '{16'h0008, 16'hFFFF, 1'b0, 1'b0, 1'b1, 4'd3, 16'h0000, 16'd0};
        tbl[4]  = '{16'h0008, 16'hFFFF, 1'b0, 1'b0, 1'b1, 4'd3, 16'h0000, 16'd0};
        tbl[5]  = '{16'h0008, 16'hFFFF, 1'b1, 1'b0, 1'b1, 4'd3, 16'h0008, 16'd1};
        tbl[6]  = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd3, 16'h0000, 16'd1};
        tbl[7]  = '{16'h0009, 16'hFFFF, 1'b0, 1'b1, 1'b1, 4'd0, 16'h0000, 16'd1};
        tbl[8]  = '{16'h0009, 16'hFFFF, 1'b1, 1'b0, 1'b1, 4'd0, 16'h0000, 16'd1};
        tbl[9]  = '{16'h0009, 16'hFFFF, 1'b1, 1'b0, 1'b1, 4'd0, 16'h0001, 16'd2};
        tbl[10] = '{16'h0009, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 16'd2};
        tbl[11] = '{16'h0009, 16'hFFFF, 1'b0, 1'b1, 1'b1, 4'd3, 16'h0000, 16'd2};
        tbl[12] = '{16'h0009, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd3, 16'h0000, 16'd2};
        tbl[13] = '{16'h0009, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd3, 16'h0008, 16'd3};
        tbl[14] = '{16'h0009, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd3, 16'h0000, 16'd3};
        tbl[15] = '{16'h0009, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd3, 16'h0000, 16'd3};
        tbl[16] = '{16'h0009, 16'h0001, 1'b0, 1'b1, 1'b1, 4'd0, 16'h0000, 16'd3};
        tbl[17] = '{16'h0009, 16'h0001, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0000, 16'd3};
        tbl[18] = '{16'h0009, 16'h0001, 1'b1, 1'b0, 1'b1, 4'd0, 16'h0001, 16'd4};
        tbl[19] = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'd4};

        // Reset held with toggling inputs, release, then async drop mid-START
        for (int i = 0; i < 5; i++) begin
            req = 16'($urandom); en = 16'($urandom); done = 1'($urandom);
            step();
            chk("reset_hold", outs(), 64'd0);
        end
        req = 16'h0001; en = 16'h0001; done = 1'b0;
        rst = 1'b0;
        step();
        chk("rel_start", 64'({dma_start, dma_busy, dma_ep}), 64'({1'b1, 1'b1, 4'd0}));
        rst = 1'b1;
        #1;
        chk("async_start_drop", outs(), 64'd0);
        step();
        rst = 1'b0; req = '0; en = '0;
        step();

        // Vector table
        do_reset();
        for (int i = 0; i < 20; i++) begin
            req = tbl[i].req; en = tbl[i].en; done = tbl[i].done;
            step();
            chk($sformatf("vec%0d", i),
                64'({dma_start, dma_busy, dma_ep, ep_dma_ack, tmo_err, xfer_cnt}),
                64'({tbl[i].start, tbl[i].busy, tbl[i].ep, tbl[i].ack, 1'b0, tbl[i].cnt}));
        end

        // Round-robin over endpoints 0, 1, 5
        do_reset();
        rr_exp = '{4'd0, 4'd1, 4'd5, 4'd0, 4'd1, 4'd5};
        req = 16'h0023; en = 16'hFFFF;
        for (int g = 0; g < 6; g++) begin
            wait_start(20, ok);
            chk($sformatf("rr_ep%0d", g), 64'(dma_ep), 64'(rr_exp[g]));
            step();
            done = 1'b1;
            step();
            done = 1'b0;
            chk($sformatf("rr_ack%0d", g), 64'(ep_dma_ack), 64'(16'h1 << rr_exp[g]));
        end
        chk("rr_cnt", 64'(xfer_cnt), 64'd6);

        // Masked request never granted until enabled
        do_reset();
        req = 16'h0004; en = 16'hFFFB; busy_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (dma_busy) busy_cyc++;
        end
        chk("mask_busy", 64'(busy_cyc), 64'd0);
        en = 16'hFFFF;
        wait_start(5, ok);
        chk("mask_ep", 64'(dma_ep), 64'd2);
        step(); done = 1'b1; step(); done = 1'b0;
        chk("mask_ack", 64'(ep_dma_ack), 64'h0004);
        req = '0;

        // Timeout on ep 7, then next grant above it
        req = 16'h0080;
        wait_start(10, ok);
        chk("tmo_ep", 64'(dma_ep), 64'd7);
        req = 16'h0284;
        n = 0; acks = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            n++;
            if (ep_dma_ack != 0) acks++;
            if (tmo_err) break;
        end
        chk("tmo_latency", 64'(n), 64'd256);
        chk("tmo_noack", 64'(acks), 64'd0);
        chk("tmo_cnt", 64'(xfer_cnt), 64'd1);
        step();
        chk("tmo_pulse", 64'(tmo_err), 64'd0);
        wait_start(10, ok);
        chk("tmo_next_ep", 64'(dma_ep), 64'd9);
        step(); done = 1'b1; step(); done = 1'b0;
        req = '0;

        // dma_done on the timeout cycle wins
        req = 16'h0010;
        wait_start(10, ok);
        chk("coin_ep", 64'(dma_ep), 64'd4);
        tseen = 1'b0;
        for (int i = 0; i < 255; i++) begin
            step();
            if (tmo_err) tseen = 1'b1;
        end
        done = 1'b1;
        step();
        done = 1'b0;
        chk("coin_ack", 64'({ep_dma_ack, tmo_err, tseen}), 64'({16'h0010, 1'b0, 1'b0}));
        req = '0;

        // Async reset mid-WAIT drops outputs and resets the pointer
        req = 16'h0400;
        wait_start(10, ok);
        chk("arst_ep", 64'(dma_ep), 64'd10);
        step(); step();
        rst = 1'b1;
        #1;
        chk("arst_drop", 64'({dma_busy, dma_ep, ep_dma_ack, dma_start}), 64'd0);
        step();
        rst = 1'b0; req = 16'h0801;
        wait_start(10, ok);
        chk("arst_rr0", 64'({dma_ep, xfer_cnt}), 64'({4'd0, 16'd0}));
        step(); done = 1'b1; step(); done = 1'b0; req = '0;

        // Randomized run against the reference model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst = (i == 2000);
            req = 16'($urandom);
            if ($urandom_range(0, 1) == 1) req = req & 16'($urandom);
            en = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
            if ((i / 700) % 3 == 2) done = 1'b0;
            else done = ($urandom_range(0, 5) == 0);
            step();
            chk("rand_cycle", outs(),
                64'({m_ack, m_start, m_ep, m_busy, m_tmo, m_cnt}));
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
